// File: rtl/instr_mem_banked.sv
// Banked writable instruction store with registered fetch and field decode.
// Latency: 1 cycle from fetch_req to instr_valid; writes land on the clock edge.
// Backpressure: stall freezes every fetch output and drops the request; writes proceed.
// Optional feature: INSTR_PARITY_EN adds a stored even-parity bit and parity_err checking.
module instr_mem_banked #(
    parameter int DEPTH     = 128,
    parameter int NUM_BANKS = 4,
    parameter int PC_W      = 16,
    parameter int BANK_W    = 2,
    parameter int ADDR_W    = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BANK_W-1:0] bank_sel,
    input  logic              fetch_req,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              stall,
    input  logic              wr_en,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [8:0]        wr_data,
    output logic              instr_valid,
    output logic [8:0]        instr_raw,
    output logic [PC_W-1:0]   pc_out,
    output logic              format,
    output logic [3:0]        opcode,
    output logic              sign,
    output logic [2:0]        operand,
    output logic [7:0]        immediate,
    output logic              oob_err,
    output logic              parity_err
);

`ifdef INSTR_PARITY_EN
    localparam int STORE_W = 10;
`else
    localparam int STORE_W = 9;
`endif

    // One extra bit on the bank compare so a non-power-of-two bank count is representable.
    localparam logic [BANK_W:0]  BANK_LIM = (BANK_W+1)'(NUM_BANKS);
    localparam logic [PC_W-1:0]  PC_LIM   = PC_W'(DEPTH);

    // Flat store: bank in the upper index bits, word address in the lower bits.
    logic [STORE_W-1:0] mem [NUM_BANKS*DEPTH];

    logic [BANK_W-1:0]        bank_q;
    logic                     pc_oob;
    logic                     bank_oob;
    logic                     fetch_oob;
    logic                     wr_ok;
    logic                     rd_par_bad;
    logic [BANK_W+ADDR_W-1:0] rd_idx;
    logic [BANK_W+ADDR_W-1:0] wr_idx;
    logic [STORE_W-1:0]       rd_word;
    logic [STORE_W-1:0]       wr_word;

    assign pc_oob    = (pc_in >= PC_LIM);
    assign bank_oob  = ({1'b0, bank_q} >= BANK_LIM);
    assign fetch_oob = pc_oob | bank_oob;
    assign wr_ok     = wr_en & ({1'b0, wr_bank} < BANK_LIM);

    // Out-of-range fetches never touch the array; the NOP is substituted below.
    assign rd_idx  = fetch_oob ? '0 : {bank_q, pc_in[ADDR_W-1:0]};
    assign wr_idx  = {wr_bank, wr_addr};
    assign rd_word = mem[rd_idx];

`ifdef INSTR_PARITY_EN
    assign wr_word    = {^wr_data, wr_data};
    assign rd_par_bad = (^rd_word[8:0]) != rd_word[9];
`else
    assign wr_word    = wr_data;
    assign rd_par_bad = 1'b0;
`endif

    // Write port: independent of stall and reset; invalid banks are discarded.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= wr_word;
        end
    end

    // Fetch pipeline register: read-before-write ordering falls out of the NBA update.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q      <= '0;
            instr_valid <= 1'b0;
            instr_raw   <= '0;
            pc_out      <= '0;
            oob_err     <= 1'b0;
            parity_err  <= 1'b0;
        end else if (!stall) begin
            instr_valid <= fetch_req;
            if (fetch_req) begin
                pc_out     <= pc_in;
                instr_raw  <= fetch_oob ? 9'b0 : rd_word[8:0];
                oob_err    <= fetch_oob;
                parity_err <= ~fetch_oob & rd_par_bad;
            end else begin
                // Bank only changes between fetches so a stream never mixes programs.
                bank_q     <= bank_sel;
                oob_err    <= 1'b0;
                parity_err <= 1'b0;
            end
        end
    end

    assign format    = instr_raw[8];
    assign opcode    = instr_raw[7:4];
    assign sign      = instr_raw[3];
    assign operand   = instr_raw[2:0];
    assign immediate = instr_raw[7:0];

endmodule

// File: tb/tb_instr_mem_banked.sv
// Bench for instr_mem_banked: vector table plus hand sequences, scoreboard queue.
// Built with three banks so bank index 3 is out of range for fetch and write.
module tb_instr_mem_banked;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  bank_sel = '0;
    logic        fetch_req = 1'b0;
    logic [15:0] pc_in = '0;
    logic        stall = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_bank = '0;
    logic [6:0]  wr_addr = '0;
    logic [8:0]  wr_data = '0;
    logic        instr_valid;
    logic [8:0]  instr_raw;
    logic [15:0] pc_out;
    logic        format;
    logic [3:0]  opcode;
    logic        sign;
    logic [2:0]  operand;
    logic [7:0]  immediate;
    logic        oob_err;
    logic        parity_err;

    int checks = 0;
    int failures = 0;

    instr_mem_banked #(
        .DEPTH(128), .NUM_BANKS(3), .PC_W(16), .BANK_W(2), .ADDR_W(7)
    ) dut (
        .clk(clk), .reset(reset), .bank_sel(bank_sel), .fetch_req(fetch_req),
        .pc_in(pc_in), .stall(stall), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_addr(wr_addr), .wr_data(wr_data), .instr_valid(instr_valid),
        .instr_raw(instr_raw), .pc_out(pc_out), .format(format), .opcode(opcode),
        .sign(sign), .operand(operand), .immediate(immediate), .oob_err(oob_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

`ifdef INSTR_PARITY_EN
    localparam logic [8:0] PAR_RAW = 9'h0A4;
    localparam logic       PAR_ERR = 1'b1;
`else
    localparam logic [8:0] PAR_RAW = 9'h0A5;
    localparam logic       PAR_ERR = 1'b0;
`endif

    typedef struct {
        logic [8*10-1:0] nm;
        logic        rst;
        logic        req;
        logic [15:0] pc;
        logic        stl;
        logic [1:0]  bsel;
        logic        we;
        logic [1:0]  wb;
        logic [6:0]  wa;
        logic [8:0]  wd;
        logic        ev;
        logic [8:0]  eraw;
        logic [15:0] epc;
        logic        eoob;
        logic        epar;
    } vec_t;

    // Expected output vectors, pushed at drive time and popped after the edge.
    logic [44:0] sb_q[$];
    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [8*10-1:0] nm, input logic rst, input logic req, input logic [15:0] pc,
        input logic stl, input logic [1:0] bsel, input logic we, input logic [1:0] wb,
        input logic [6:0] wa, input logic [8:0] wd, input logic ev, input logic [8:0] eraw,
        input logic [15:0] epc, input logic eoob, input logic epar);
        vec_t v;
        v.nm = nm; v.rst = rst; v.req = req; v.pc = pc; v.stl = stl; v.bsel = bsel;
        v.we = we; v.wb = wb; v.wa = wa; v.wd = wd; v.ev = ev; v.eraw = eraw;
        v.epc = epc; v.eoob = eoob; v.epar = epar;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        logic [44:0] exp_v;
        logic [44:0] act_v;
        reset = v.rst; fetch_req = v.req; pc_in = v.pc; stall = v.stl; bank_sel = v.bsel;
        wr_en = v.we; wr_bank = v.wb; wr_addr = v.wa; wr_data = v.wd;
        sb_q.push_back({v.ev, v.eraw, v.epc, v.eoob, v.epar,
                        v.eraw[8], v.eraw[7:4], v.eraw[3], v.eraw[2:0], v.eraw[7:0]});
        @(posedge clk);
        #1;
        act_v = {instr_valid, instr_raw, pc_out, oob_err, parity_err,
                 format, opcode, sign, operand, immediate};
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %0s: scoreboard empty, actual=%h", v.nm, act_v);
        end else begin
            exp_v = sb_q.pop_front();
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL %0s: actual {v,raw,pc,oob,par,dec}=%h required=%h", v.nm, act_v, exp_v);
            end
        end
    endtask

    task automatic chk(input logic [8*10-1:0] nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %0s: actual=%h required=%h", nm, act, req);
        end
    endtask

    initial begin
        // Reset, single write, fetch and decode.
        run_vec(mk("rst",    1,0,16'd0,0,0, 0,0,7'd0,9'h000, 0,9'h000,16'd0,0,0));
        run_vec(mk("idle",   0,0,16'd0,0,0, 0,0,7'd0,9'h000, 0,9'h000,16'd0,0,0));
        run_vec(mk("wr178",  0,0,16'd0,0,0, 1,0,7'd1,9'h178, 0,9'h000,16'd0,0,0));
        run_vec(mk("fetch1", 0,1,16'd1,0,0, 0,0,7'd0,9'h000, 1,9'h178,16'd1,0,0));
        chk("dec_fmt", {15'd0, format},    16'd1);
        chk("dec_opc", {12'd0, opcode},    16'h7);
        chk("dec_sgn", {15'd0, sign},      16'd1);
        chk("dec_opr", {13'd0, operand},   16'd0);
        chk("dec_imm", {8'd0, immediate},  16'h78);

        // Bank load, streaming, bank switch only between fetches, out-of-range, write rules.
        tbl.push_back(mk("w_b0_0", 0,0,16'd0,0,0, 1,0,7'd0,9'h011, 0,9'h178,16'd1,0,0));
        tbl.push_back(mk("w_b0_1", 0,0,16'd0,0,0, 1,0,7'd1,9'h022, 0,9'h178,16'd1,0,0));
        tbl.push_back(mk("w_b0_2", 0,0,16'd0,0,0, 1,0,7'd2,9'h033, 0,9'h178,16'd1,0,0));
        tbl.push_back(mk("w_b0_3", 0,0,16'd0,0,0, 1,0,7'd3,9'h044, 0,9'h178,16'd1,0,0));
        tbl.push_back(mk("w_b1_0", 0,0,16'd0,0,0, 1,1,7'd0,9'h1C1, 0,9'h178,16'd1,0,0));
        tbl.push_back(mk("w_b1_1", 0,0,16'd0,0,0, 1,1,7'd1,9'h1C2, 0,9'h178,16'd1,0,0));
        tbl.push_back(mk("w_b1_2", 0,0,16'd0,0,0, 1,1,7'd2,9'h1C3, 0,9'h178,16'd1,0,0));
        tbl.push_back(mk("w_b1_3", 0,0,16'd0,0,1, 1,1,7'd3,9'h1C4, 0,9'h178,16'd1,0,0));
        tbl.push_back(mk("str0",   0,1,16'd0,0,1, 0,0,7'd0,9'h000, 1,9'h1C1,16'd0,0,0));
        tbl.push_back(mk("str1",   0,1,16'd1,0,0, 0,0,7'd0,9'h000, 1,9'h1C2,16'd1,0,0));
        tbl.push_back(mk("str2",   0,1,16'd2,0,0, 0,0,7'd0,9'h000, 1,9'h1C3,16'd2,0,0));
        tbl.push_back(mk("str3",   0,1,16'd3,0,0, 0,0,7'd0,9'h000, 1,9'h1C4,16'd3,0,0));
        tbl.push_back(mk("gap",    0,0,16'd0,0,0, 0,0,7'd0,9'h000, 0,9'h1C4,16'd3,0,0));
        tbl.push_back(mk("switch", 0,1,16'd2,0,0, 0,0,7'd0,9'h000, 1,9'h033,16'd2,0,0));
        tbl.push_back(mk("oob128", 0,1,16'd128,0,0, 0,0,7'd0,9'h000, 1,9'h000,16'd128,1,0));
        tbl.push_back(mk("oobhi",  0,1,16'h8001,0,0, 0,0,7'd0,9'h000, 1,9'h000,16'h8001,1,0));
        tbl.push_back(mk("pc0",    0,1,16'd0,0,0, 0,0,7'd0,9'h000, 1,9'h011,16'd0,0,0));
        tbl.push_back(mk("selb3",  0,0,16'd0,0,3, 0,0,7'd0,9'h000, 0,9'h011,16'd0,0,0));
        tbl.push_back(mk("bankoob",0,1,16'd1,0,3, 0,0,7'd0,9'h000, 1,9'h000,16'd1,1,0));
        tbl.push_back(mk("selb0",  0,0,16'd0,0,0, 0,0,7'd0,9'h000, 0,9'h000,16'd1,0,0));
        tbl.push_back(mk("w7old",  0,0,16'd0,0,0, 1,0,7'd7,9'h055, 0,9'h000,16'd1,0,0));
        tbl.push_back(mk("rawsame",0,1,16'd7,0,0, 1,0,7'd7,9'h1B0, 1,9'h055,16'd7,0,0));
        tbl.push_back(mk("refetch",0,1,16'd7,0,0, 0,0,7'd0,9'h000, 1,9'h1B0,16'd7,0,0));
        tbl.push_back(mk("wbadbnk",0,0,16'd0,0,0, 1,3,7'd7,9'h0FF, 0,9'h1B0,16'd7,0,0));
        tbl.push_back(mk("chk7",   0,1,16'd7,0,0, 0,0,7'd0,9'h000, 1,9'h1B0,16'd7,0,0));
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i]);
        end

        // Stall: outputs frozen three cycles, request presented during stall is dropped.
        run_vec(mk("w5",     0,0,16'd0,0,0, 1,0,7'd5,9'h1A5, 0,9'h1B0,16'd7,0,0));
        run_vec(mk("w6",     0,0,16'd0,0,0, 1,0,7'd6,9'h066, 0,9'h1B0,16'd7,0,0));
        run_vec(mk("f5",     0,1,16'd5,0,0, 0,0,7'd0,9'h000, 1,9'h1A5,16'd5,0,0));
        for (int i = 0; i < 3; i++) begin
            run_vec(mk("stall",  0,1,16'd6,1,0, 0,0,7'd0,9'h000, 1,9'h1A5,16'd5,0,0));
        end
        run_vec(mk("poststl",0,0,16'd0,0,0, 0,0,7'd0,9'h000, 0,9'h1A5,16'd5,0,0));

        // Error flag held through a stall, cleared on the next non-stalled update.
        run_vec(mk("oobs",   0,1,16'd128,0,0, 0,0,7'd0,9'h000, 1,9'h000,16'd128,1,0));
        run_vec(mk("oobhold",0,1,16'd0,1,0, 0,0,7'd0,9'h000, 1,9'h000,16'd128,1,0));
        run_vec(mk("oobclr", 0,0,16'd0,0,0, 0,0,7'd0,9'h000, 0,9'h000,16'd128,0,0));

        // Reset mid-fetch loses the fetch but still performs the write.
        run_vec(mk("f5b",    0,1,16'd5,0,0, 0,0,7'd0,9'h000, 1,9'h1A5,16'd5,0,0));
        run_vec(mk("rstmid", 1,1,16'd6,0,0, 1,0,7'd9,9'h099, 0,9'h000,16'd0,0,0));
        run_vec(mk("rstidle",0,0,16'd0,0,0, 0,0,7'd0,9'h000, 0,9'h000,16'd0,0,0));
        run_vec(mk("f9",     0,1,16'd9,0,0, 0,0,7'd0,9'h000, 1,9'h099,16'd9,0,0));

        // Parity: corrupt stored bit 0 when the feature is built in.
        run_vec(mk("w20",    0,0,16'd0,0,0, 1,0,7'd20,9'h0A5, 0,9'h099,16'd9,0,0));
`ifdef INSTR_PARITY_EN
        dut.mem[20] = dut.mem[20] ^ 10'h001;
`endif
        run_vec(mk("par20",  0,1,16'd20,0,0, 0,0,7'd0,9'h000, 1,PAR_RAW,16'd20,0,PAR_ERR));
        run_vec(mk("parclr", 0,0,16'd0,0,0, 0,0,7'd0,9'h000, 0,PAR_RAW,16'd20,0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
